stream_in: RTL
==============

Name: stream_in

Overview:
- Serial-to-bus deserializer: the receiving end of the systolic-array serial stream.
- Collects TOTAL_ELEM consecutive valid beats into a TOTAL_ELEM-wide bus and presents the completed frame with a valid/ready handshake.
- Ordering matches the stream transmitter: first beat lands in bus element 0, last beat in element TOTAL_ELEM-1, so transmit-then-receive reproduces the original bus.
- Sits between serial links and array input/weight registers.

Parameters:
- DATA_WIDTH, 16, width of one element.
- RESET_VAL, 0, value of every bus element after reset/clear.
- TOTAL_ELEM, 10, elements per frame; must be >= 2.
- IDX_WIDTH, $clog2(TOTAL_ELEM), derived; not to be overridden.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous active-low reset.
- stream_data_i  input  DATA_WIDTH  serial element.
- stream_valid_i  input  1  beat qualifier; no backpressure on the stream side.
- stream_clr_i  input  1  synchronous clear of frame progress, output and flags.
- bus_data_o  output  [TOTAL_ELEM-1:0][DATA_WIDTH-1:0]  completed frame.
- bus_valid_o  output  1  frame available.
- bus_ready_i  input  1  consumer accepts the frame.
- frame_busy_o  output  1  partial frame in progress (index != 0).
- overflow_o  output  1  sticky: a completed frame was dropped.

Behaviour:
- One clock; reset is asynchronous and active-low on rst_ni.
- Reset values:
  - index = 0.
  - Shadow buffer and bus_data_o elements = RESET_VAL.
  - bus_valid_o = 0, overflow_o = 0.
  - frame_busy_o = 0 (combinational from index).
- Fill:
  - Each cycle with stream_valid_i=1 writes shadow[index] <= stream_data_i.
  - index increments, wrapping TOTAL_ELEM-1 -> 0.
  - Beats with stream_valid_i=0 are ignored; gaps of any length are allowed inside a frame.
- Completion (valid beat at index = TOTAL_ELEM-1): on the same edge, the output register loads shadow[0..TOTAL_ELEM-2] plus stream_data_i as element TOTAL_ELEM-1.
  - bus_valid_o is 1 in the cycle after the last beat (latency 1).
- Handshake:
  - A transfer occurs when bus_valid_o && bus_ready_i; bus_valid_o then clears next cycle unless a new frame completes on that edge.
  - bus_data_o and bus_valid_o are stable while bus_valid_o=1 and bus_ready_i=0.
  - bus_data_o holds its value after transfer; it is meaningless while bus_valid_o=0.
- Completion with output pending and no transfer that cycle:
  - New frame is dropped; bus_data_o and bus_valid_o unchanged.
  - overflow_o is set and stays set until stream_clr_i or reset.
  - index still wraps to 0.
- Completion in the same cycle as a transfer: new frame is loaded, bus_valid_o stays 1, no overflow.
- stream_clr_i has priority over everything:
  - Next cycle: index = 0, bus_valid_o = 0, overflow_o = 0, bus_data_o = RESET_VAL.
  - A beat presented with clear is discarded; shadow contents need not be cleared.
- Reset mid-frame: all state returns to reset values immediately; the partial frame is lost.
- Widths: index is IDX_WIDTH bits; the wrap is by compare to TOTAL_ELEM-1, not natural overflow (TOTAL_ELEM need not be a power of 2).
- No combinational path from stream_* to bus_* outputs; bus_valid_o depends only on registers.

Decomposition:
- Shared systolic-array package holds default DATA_WIDTH/TOTAL_ELEM constants and the element typedef (logic [DATA_WIDTH-1:0]) used by both stream_out and stream_in.
- Block stays flat: one index counter, shadow array, output register, flag registers. No sub-module is warranted.

Test Plan (DATA_WIDTH=16, TOTAL_ELEM=4, RESET_VAL=0):
- Back-to-back beats 0x11,0x22,0x33,0x44 with bus_ready_i=1 -> cycle after 0x44: bus_valid_o=1 for 1 cycle, bus_data_o[0..3]=0x11,0x22,0x33,0x44, frame_busy_o=0.
- Same frame with stream_valid_i gaps of 3 idle cycles between beats -> identical bus_data_o; frame_busy_o=1 from first beat until last.
- bus_ready_i=0, send frame A then frame B (0xA0..0xA3, 0xB0..0xB3) -> bus_data_o holds A, overflow_o=1 after B's last beat; raise ready -> A transferred, bus_valid_o=0.
- bus_ready_i asserted exactly in B's completion cycle -> A transfers, B loads, bus_valid_o continuous, overflow_o=0.
- stream_clr_i after 2 beats of 0x55,0x66, then beats 0x01..0x04 -> bus_data_o=0x01,0x02,0x03,0x04; clear also drops bus_valid_o and overflow_o.
- rst_ni low for 1 cycle mid-frame and mid-pending-output -> all outputs reset asynchronously; next 4 beats form a clean frame; round-trip through stream_out reproduces its input bus.

Source files
------------

// File: rtl/stream_in_pkg.sv
// Shared constants and element type for the systolic-array serial stream
// (transmitter and receiver sides).
package stream_in_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_TOTAL_ELEM = 10;

  typedef logic [DEF_DATA_WIDTH-1:0] elem_t;

endpackage

// File: rtl/stream_in.sv
// Serial-to-bus deserializer: gathers TOTAL_ELEM valid beats into one frame
// and offers it on a registered valid/ready output.
module stream_in
  import stream_in_pkg::*;
#(
  parameter int unsigned                   DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0]         RESET_VAL  = '0,
  parameter int unsigned                   TOTAL_ELEM = DEF_TOTAL_ELEM,
  parameter int unsigned                   IDX_WIDTH  = $clog2(TOTAL_ELEM)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [DATA_WIDTH-1:0]                  stream_data_i,
  input  logic                                   stream_valid_i,
  input  logic                                   stream_clr_i,
  output logic [TOTAL_ELEM-1:0][DATA_WIDTH-1:0]  bus_data_o,
  output logic                                   bus_valid_o,
  input  logic                                   bus_ready_i,
  output logic                                   frame_busy_o,
  output logic                                   overflow_o
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(TOTAL_ELEM - 1);

  // The last beat never sits in the shadow: it goes straight into the
  // output register on the completing edge.
  logic [DATA_WIDTH-1:0] shadow_q [0:TOTAL_ELEM-2];
  logic [IDX_WIDTH-1:0]  idx_q;

  logic last_beat;
  logic xfer;
  logic load_frame;
  logic drop_frame;

  // Handshake: a frame is handed over on every edge where bus_valid_o and
  // bus_ready_i are both high; while bus_valid_o is high and bus_ready_i low,
  // bus_data_o/bus_valid_o are frozen. bus_valid_o comes only from a register.
  assign last_beat  = stream_valid_i && (idx_q == LAST_IDX);
  assign xfer       = bus_valid_o && bus_ready_i;
  assign load_frame = last_beat && (!bus_valid_o || bus_ready_i);
  assign drop_frame = last_beat && bus_valid_o && !bus_ready_i;

  assign frame_busy_o = (idx_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q       <= '0;
      bus_valid_o <= 1'b0;
      overflow_o  <= 1'b0;
      for (int i = 0; i < TOTAL_ELEM - 1; i++) shadow_q[i] <= RESET_VAL;
      for (int i = 0; i < TOTAL_ELEM; i++) bus_data_o[i] <= RESET_VAL;
    end else if (stream_clr_i) begin
      idx_q       <= '0;
      bus_valid_o <= 1'b0;
      overflow_o  <= 1'b0;
      for (int i = 0; i < TOTAL_ELEM; i++) bus_data_o[i] <= RESET_VAL;
    end else begin
      if (stream_valid_i) begin
        idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        for (int i = 0; i < TOTAL_ELEM - 1; i++) begin
          if (idx_q == IDX_WIDTH'(i)) shadow_q[i] <= stream_data_i;
        end
      end

      if (load_frame) begin
        for (int i = 0; i < TOTAL_ELEM - 1; i++) bus_data_o[i] <= shadow_q[i];
        bus_data_o[TOTAL_ELEM-1] <= stream_data_i;
        bus_valid_o              <= 1'b1;
      end else if (xfer) begin
        bus_valid_o <= 1'b0;
      end

      if (drop_frame) overflow_o <= 1'b1;
    end
  end

endmodule
